// File: rtl/text_writer.sv
// rtl/text_writer.sv - character stream to character-memory cell writer with managed text cursor
//
// Purpose: accepts ASCII characters from a mode (keyboard/terminal logic) and turns
// them into registered cell writes at a cursor owned by this block. Handles printable
// characters, newline, carriage return, backspace, line wrap with row-0 clear on
// screen overflow, and full-screen clear.
//
// Optional feature: define TEXT_WRITER_CURSOR_HL_EN to add the cursor highlight
// outputs (hix, hiy, hien, highlight).
//
// Ports:
//   clock, reset        single clock; asynchronous active-high reset
//   sL                  grid select: 0 = 80x60, 1 = 40x30 (sampled only in IDLE)
//   char_valid/ascii/colour, char_ready   character offer handshake
//   clear_req           full-screen clear request (wins over a character)
//   busy                high whenever not IDLE
//   cursor_x, cursor_y  current cursor cell
//   wrx, wry, wren, wascii, wcolour       registered character-memory write port
//   hix, hiy, hien, highlight             (optional) cursor highlight write port
module text_writer #(
  parameter logic [6:0] CLEAR_ASCII  = 7'h20,
  parameter logic [5:0] CLEAR_COLOUR = 6'b000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sL,
  input  logic       char_valid,
  input  logic [6:0] char_ascii,
  input  logic [5:0] char_colour,
  output logic       char_ready,
  input  logic       clear_req,
  output logic       busy,
  output logic [6:0] cursor_x,
  output logic [5:0] cursor_y,
  output logic [6:0] wrx,
  output logic [5:0] wry,
  output logic       wren,
  output logic [6:0] wascii,
  output logic [5:0] wcolour
`ifdef TEXT_WRITER_CURSOR_HL_EN
  ,
  output logic [6:0] hix,
  output logic [5:0] hiy,
  output logic       hien,
  output logic       highlight
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_CLEAR_ROW, S_CLEAR, S_HL_OLD, S_HL_NEW
  } state_t;

  state_t     r_state, w_state_nxt;
  logic       r_mode, w_mode_nxt;
  logic [6:0] r_cur_x, w_cur_x_nxt;
  logic [5:0] r_cur_y, w_cur_y_nxt;
  logic [6:0] r_cnt_x, w_cnt_x_nxt;
  logic [5:0] r_cnt_y, w_cnt_y_nxt;
  logic [6:0] r_char, w_char_nxt;
  logic [6:0] r_wrx, w_wrx_nxt;
  logic [5:0] r_wry, w_wry_nxt;
  logic       r_wren, w_wren_nxt;
  logic [6:0] r_wascii, w_wascii_nxt;
  logic [5:0] r_wcolour, w_wcolour_nxt;

  logic       w_mode_eff;
  logic       w_mode_chg;
  logic [6:0] w_last_x;
  logic [5:0] w_last_y;
  logic [6:0] w_base_x;
  logic [5:0] w_base_y;
  logic [6:0] w_adv_x;
  logic [5:0] w_adv_y;
  logic       w_row_inc;
  logic       w_printable;

`ifdef TEXT_WRITER_CURSOR_HL_EN
  logic [6:0] r_hl_x, w_hl_x_nxt;
  logic [5:0] r_hl_y, w_hl_y_nxt;
  logic [6:0] r_hix, w_hix_nxt;
  logic [5:0] r_hiy, w_hiy_nxt;
  logic       r_hien, w_hien_nxt;
  logic       r_highlight, w_highlight_nxt;
  logic       w_hl_sync;

  // The highlighted cell lags the cursor; any mismatch means a move is pending display.
  assign w_hl_sync = (r_cur_x == r_hl_x) && (r_cur_y == r_hl_y);
  assign char_ready = (r_state == S_IDLE) & ~clear_req & w_hl_sync;
  assign hix       = r_hix;
  assign hiy       = r_hiy;
  assign hien      = r_hien;
  assign highlight = r_highlight;
`else
  assign char_ready = (r_state == S_IDLE) & ~clear_req;
`endif

  assign busy     = (r_state != S_IDLE);
  assign cursor_x = r_cur_x;
  assign cursor_y = r_cur_y;
  assign wrx      = r_wrx;
  assign wry      = r_wry;
  assign wren     = r_wren;
  assign wascii   = r_wascii;
  assign wcolour  = r_wcolour;

  // In IDLE the mode is being resampled from sL this very edge, so the grid size
  // and cursor used for the write issued at acceptance must follow sL directly.
  assign w_mode_eff = (r_state == S_IDLE) ? sL : r_mode;
  assign w_mode_chg = (r_state == S_IDLE) && (sL != r_mode);
  assign w_last_x   = w_mode_eff ? 7'd39 : 7'd79;
  assign w_last_y   = w_mode_eff ? 6'd29 : 6'd59;
  assign w_base_x   = w_mode_chg ? 7'd0 : r_cur_x;
  assign w_base_y   = w_mode_chg ? 6'd0 : r_cur_y;
  assign w_printable = (r_char >= 7'h20) && (r_char <= 7'h7E);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_mode_nxt    = r_mode;
    w_cur_x_nxt   = r_cur_x;
    w_cur_y_nxt   = r_cur_y;
    w_cnt_x_nxt   = r_cnt_x;
    w_cnt_y_nxt   = r_cnt_y;
    w_char_nxt    = r_char;
    w_wrx_nxt     = r_wrx;
    w_wry_nxt     = r_wry;
    w_wren_nxt    = 1'b0;
    w_wascii_nxt  = r_wascii;
    w_wcolour_nxt = r_wcolour;
    w_adv_x       = r_cur_x;
    w_adv_y       = r_cur_y;
    w_row_inc     = 1'b0;
`ifdef TEXT_WRITER_CURSOR_HL_EN
    w_hl_x_nxt      = r_hl_x;
    w_hl_y_nxt      = r_hl_y;
    w_hix_nxt       = r_hix;
    w_hiy_nxt       = r_hiy;
    w_hien_nxt      = 1'b0;
    w_highlight_nxt = 1'b0;
`endif

    case (r_state)
      S_IDLE: begin
        w_mode_nxt  = sL;
        w_cur_x_nxt = w_base_x;
        w_cur_y_nxt = w_base_y;
`ifdef TEXT_WRITER_CURSOR_HL_EN
        if (!w_hl_sync) begin
          w_state_nxt = S_HL_OLD;
          w_hien_nxt  = 1'b1;
          w_hix_nxt   = r_hl_x;
          w_hiy_nxt   = r_hl_y;
        end else
`endif
        if (clear_req) begin
          w_state_nxt   = S_CLEAR;
          w_cur_x_nxt   = 7'd0;
          w_cur_y_nxt   = 6'd0;
          w_cnt_x_nxt   = 7'd0;
          w_cnt_y_nxt   = 6'd0;
          w_wren_nxt    = 1'b1;
          w_wrx_nxt     = 7'd0;
          w_wry_nxt     = 6'd0;
          w_wascii_nxt  = CLEAR_ASCII;
          w_wcolour_nxt = CLEAR_COLOUR;
        end else if (char_valid) begin
          w_state_nxt = S_WRITE;
          w_char_nxt  = char_ascii;
          // The cell write is issued from the acceptance edge so wren is high
          // during the WRITE cycle; the cursor itself moves at the end of WRITE.
          if ((char_ascii >= 7'h20) && (char_ascii <= 7'h7E)) begin
            w_wren_nxt    = 1'b1;
            w_wrx_nxt     = w_base_x;
            w_wry_nxt     = w_base_y;
            w_wascii_nxt  = char_ascii;
            w_wcolour_nxt = char_colour;
          end else if ((char_ascii == 7'h08) && ((w_base_x != 7'd0) || (w_base_y != 6'd0))) begin
            w_wren_nxt    = 1'b1;
            w_wrx_nxt     = (w_base_x == 7'd0) ? w_last_x : w_base_x - 7'd1;
            w_wry_nxt     = (w_base_x == 7'd0) ? w_base_y - 6'd1 : w_base_y;
            w_wascii_nxt  = CLEAR_ASCII;
            w_wcolour_nxt = CLEAR_COLOUR;
          end
        end
      end

      S_WRITE: begin
        if (w_printable) begin
          if (r_cur_x == w_last_x) begin
            w_adv_x   = 7'd0;
            w_row_inc = 1'b1;
          end else begin
            w_adv_x = r_cur_x + 7'd1;
          end
        end else if (r_char == 7'h0A) begin
          w_adv_x   = 7'd0;
          w_row_inc = 1'b1;
        end else if (r_char == 7'h0D) begin
          w_adv_x = 7'd0;
        end else if (r_char == 7'h08) begin
          if (r_cur_x != 7'd0) begin
            w_adv_x = r_cur_x - 7'd1;
          end else if (r_cur_y != 6'd0) begin
            w_adv_x = w_last_x;
            w_adv_y = r_cur_y - 6'd1;
          end
        end

        // Running off the bottom wraps to the top and blanks the reused row.
        if (w_row_inc && (r_cur_y == w_last_y)) begin
          w_state_nxt   = S_CLEAR_ROW;
          w_cur_x_nxt   = 7'd0;
          w_cur_y_nxt   = 6'd0;
          w_cnt_x_nxt   = 7'd0;
          w_cnt_y_nxt   = 6'd0;
          w_wren_nxt    = 1'b1;
          w_wrx_nxt     = 7'd0;
          w_wry_nxt     = 6'd0;
          w_wascii_nxt  = CLEAR_ASCII;
          w_wcolour_nxt = CLEAR_COLOUR;
        end else begin
          w_state_nxt = S_IDLE;
          w_cur_x_nxt = w_adv_x;
          w_cur_y_nxt = w_row_inc ? r_cur_y + 6'd1 : w_adv_y;
        end
      end

      S_CLEAR_ROW: begin
        if (r_cnt_x == w_last_x) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_x_nxt = r_cnt_x + 7'd1;
          w_wren_nxt  = 1'b1;
          w_wrx_nxt   = r_cnt_x + 7'd1;
          w_wry_nxt   = 6'd0;
        end
      end

      S_CLEAR: begin
        if (r_cnt_x == w_last_x) begin
          if (r_cnt_y == w_last_y) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_x_nxt = 7'd0;
            w_cnt_y_nxt = r_cnt_y + 6'd1;
            w_wren_nxt  = 1'b1;
          end
        end else begin
          w_cnt_x_nxt = r_cnt_x + 7'd1;
          w_wren_nxt  = 1'b1;
        end
        w_wrx_nxt = w_cnt_x_nxt;
        w_wry_nxt = w_cnt_y_nxt;
      end

`ifdef TEXT_WRITER_CURSOR_HL_EN
      S_HL_OLD: begin
        w_state_nxt     = S_HL_NEW;
        w_hien_nxt      = 1'b1;
        w_highlight_nxt = 1'b1;
        w_hix_nxt       = r_cur_x;
        w_hiy_nxt       = r_cur_y;
        w_hl_x_nxt      = r_cur_x;
        w_hl_y_nxt      = r_cur_y;
      end

      S_HL_NEW: begin
        w_state_nxt = S_IDLE;
      end
`endif

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // r_mode resets to 0 rather than to sL: while IDLE the effective mode is sL
  // itself, and a mismatch just after reset only re-homes a cursor already at (0,0).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mode    <= 1'b0;
      r_cur_x   <= 7'd0;
      r_cur_y   <= 6'd0;
      r_cnt_x   <= 7'd0;
      r_cnt_y   <= 6'd0;
      r_char    <= 7'd0;
      r_wrx     <= 7'd0;
      r_wry     <= 6'd0;
      r_wren    <= 1'b0;
      r_wascii  <= 7'd0;
      r_wcolour <= 6'd0;
    end else begin
      r_mode    <= w_mode_nxt;
      r_cur_x   <= w_cur_x_nxt;
      r_cur_y   <= w_cur_y_nxt;
      r_cnt_x   <= w_cnt_x_nxt;
      r_cnt_y   <= w_cnt_y_nxt;
      r_char    <= w_char_nxt;
      r_wrx     <= w_wrx_nxt;
      r_wry     <= w_wry_nxt;
      r_wren    <= w_wren_nxt;
      r_wascii  <= w_wascii_nxt;
      r_wcolour <= w_wcolour_nxt;
    end
  end

`ifdef TEXT_WRITER_CURSOR_HL_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hl_x      <= 7'd0;
      r_hl_y      <= 6'd0;
      r_hix       <= 7'd0;
      r_hiy       <= 6'd0;
      r_hien      <= 1'b0;
      r_highlight <= 1'b0;
    end else begin
      r_hl_x      <= w_hl_x_nxt;
      r_hl_y      <= w_hl_y_nxt;
      r_hix       <= w_hix_nxt;
      r_hiy       <= w_hiy_nxt;
      r_hien      <= w_hien_nxt;
      r_highlight <= w_highlight_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_text_writer.sv
// tb/tb_text_writer.sv - randomized self-checking bench for text_writer
module tb_text_writer;

  localparam logic [12:0] CLR  = {6'h00, 7'h20};
  localparam logic [12:0] SENT = 13'h1FFF;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sL = 1'b0;
  logic       char_valid = 1'b0;
  logic [6:0] char_ascii = 7'd0;
  logic [5:0] char_colour = 6'd0;
  logic       clear_req = 1'b0;
  logic       char_ready;
  logic       busy;
  logic [6:0] cursor_x;
  logic [5:0] cursor_y;
  logic [6:0] wrx;
  logic [5:0] wry;
  logic       wren;
  logic [6:0] wascii;
  logic [5:0] wcolour;

  text_writer dut (
    .clock(clock), .reset(reset), .sL(sL),
    .char_valid(char_valid), .char_ascii(char_ascii), .char_colour(char_colour),
    .char_ready(char_ready), .clear_req(clear_req), .busy(busy),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .wrx(wrx), .wry(wry), .wren(wren), .wascii(wascii), .wcolour(wcolour)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  logic [12:0] dut_mem [0:59][0:79];
  logic [12:0] ref_mem [0:59][0:79];
  int ref_mode, ref_x, ref_y;

  int wr_cnt, busy_cnt, first_cyc, last_cyc;
  int cyc = 0;
  logic [6:0] last_x, last_a;
  logic [5:0] last_y, last_c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Write-port monitor: mirrors every cell write into a shadow screen.
  always @(negedge clock) begin
    cyc++;
    if (reset === 1'b0) begin
      if (wren === 1'b1) begin
        if (wry < 6'd60 && wrx < 7'd80) dut_mem[wry][wrx] = {wcolour, wascii};
        wr_cnt++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        last_x = wrx; last_y = wry; last_a = wascii; last_c = wcolour;
      end
      if (busy === 1'b1) busy_cnt++;
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic clr_counters();
    wr_cnt = 0; busy_cnt = 0; first_cyc = -1; last_cyc = -1;
  endtask

  task automatic init_mems();
    for (int y = 0; y < 60; y++)
      for (int x = 0; x < 80; x++) begin
        dut_mem[y][x] = SENT;
        ref_mem[y][x] = SENT;
      end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    tick();
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check({tag, "_idle_timeout"}, busy, 0);
  endtask

  // Reference: cursor treated as a linear raster position p = y*W + x.
  task automatic model_char(input logic [6:0] a, input logic [5:0] c, output int ew, output int eb);
    int w, h, p;
    bit wrap;
    w = ref_mode ? 40 : 80;
    h = ref_mode ? 30 : 60;
    p = ref_y * w + ref_x;
    wrap = 0;
    ew = 0;
    if (a >= 7'h20 && a <= 7'h7E) begin
      ref_mem[ref_y][ref_x] = {c, a};
      ew = 1;
      p++;
      if (p == w * h) wrap = 1;
    end else if (a == 7'h0A) begin
      if (ref_y + 1 == h) wrap = 1;
      else p = (ref_y + 1) * w;
    end else if (a == 7'h0D) begin
      p = ref_y * w;
    end else if (a == 7'h08 && p > 0) begin
      p--;
      ref_mem[p / w][p % w] = CLR;
      ew = 1;
    end
    if (wrap) begin
      p = 0;
      for (int x = 0; x < w; x++) ref_mem[0][x] = CLR;
      ew += w;
    end
    ref_x = p % w;
    ref_y = p / w;
    eb = 1 + (wrap ? w : 0);
  endtask

  task automatic post_op(input string tag, input int ew, input int eb);
    check({tag, "_writes"}, wr_cnt, ew);
    check({tag, "_busy_cycles"}, busy_cnt, eb);
    if (ew > 0) check({tag, "_write_run"}, last_cyc - first_cyc + 1, ew);
    check({tag, "_cursor_x"}, cursor_x, ref_x);
    check({tag, "_cursor_y"}, cursor_y, ref_y);
    check({tag, "_ready"}, char_ready, 1);
  endtask

  task automatic send_char(input logic [6:0] a, input logic [5:0] c);
    int ew, eb;
    clr_counters();
    char_ascii = a;
    char_colour = c;
    char_valid = 1'b1;
    @(posedge clock);
    #1;
    char_valid = 1'b0;
    wait_idle(200, "char");
    model_char(a, c, ew, eb);
    post_op("char", ew, eb);
  endtask

  task automatic do_clear(input logic with_char);
    int w, h;
    w = ref_mode ? 40 : 80;
    h = ref_mode ? 30 : 60;
    clr_counters();
    clear_req = 1'b1;
    char_valid = with_char;
    char_ascii = 7'h51;
    char_colour = 6'h15;
    @(posedge clock);
    #1;
    clear_req = 1'b0;
    char_valid = 1'b0;
    wait_idle(6000, "clear");
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) ref_mem[y][x] = CLR;
    ref_x = 0;
    ref_y = 0;
    post_op("clear", w * h, w * h);
  endtask

  task automatic set_mode(input int m);
    sL = m[0];
    tick();
    tick();
    if (m != ref_mode) begin
      ref_x = 0;
      ref_y = 0;
    end
    ref_mode = m;
    check("mode_cursor_x", cursor_x, ref_x);
    check("mode_cursor_y", cursor_y, ref_y);
  endtask

  function automatic logic [6:0] rand_printable();
    return 7'($urandom_range(32, 126));
  endfunction

  task automatic check_screen(input string tag);
    int diff;
    diff = 0;
    for (int y = 0; y < 60; y++)
      for (int x = 0; x < 80; x++)
        if (dut_mem[y][x] !== ref_mem[y][x]) diff++;
    check(tag, diff, 0);
  endtask

  initial begin
    logic [6:0] others [5];
    int r;
    others[0] = 7'h00; others[1] = 7'h07; others[2] = 7'h09; others[3] = 7'h1B; others[4] = 7'h7F;

    init_mems();
    ref_mode = 0; ref_x = 0; ref_y = 0;

    // Reset values
    repeat (3) tick();
    check("rst_wren", wren, 0);
    check("rst_busy", busy, 0);
    check("rst_cursor_x", cursor_x, 0);
    check("rst_cursor_y", cursor_y, 0);
    check("rst_wrx", wrx, 0);
    check("rst_wry", wry, 0);
    check("rst_wascii", wascii, 0);
    check("rst_wcolour", wcolour, 0);
    reset = 1'b0;
    tick();
    check("rst_ready", char_ready, 1);

    // 'A' at the home position
    send_char(7'h41, 6'h3F);
    check("a_wrx", last_x, 0);
    check("a_wry", last_y, 0);
    check("a_wascii", last_a, 7'h41);
    check("a_wcolour", last_c, 6'h3F);

    // 40x30: printable at the last column moves to the next row
    set_mode(1);
    repeat (39) send_char(rand_printable(), 6'($urandom));
    send_char(7'h42, 6'h0A);
    check("b_wrx", last_x, 39);
    check("b_wry", last_y, 0);

    // 80x60: newline on the bottom row wraps and blanks row 0
    set_mode(0);
    repeat (59) send_char(7'h0A, 6'd0);
    repeat (5) send_char(rand_printable(), 6'($urandom));
    send_char(7'h0A, 6'd0);
    check("nl_wrap_last_x", last_x, 79);
    check("nl_wrap_last_y", last_y, 0);
    check("nl_wrap_last_a", last_a, 7'h20);

    // Clear wins over a simultaneous character
    do_clear(1'b1);
    check("clr_last_x", last_x, 79);
    check("clr_last_y", last_y, 59);
    check("clr_last_a", last_a, 7'h20);
    check("clr_last_c", last_c, 0);
    check_screen("screen_after_clear");

    // Backspace across a row boundary, then at home
    repeat (3) send_char(7'h0A, 6'd0);
    send_char(7'h08, 6'd0);
    check("bs_wrx", last_x, 79);
    check("bs_wry", last_y, 2);
    set_mode(1);
    set_mode(0);
    send_char(7'h08, 6'd0);

    // 40x30: printable at the last cell of the screen wraps
    set_mode(1);
    repeat (29) send_char(7'h0A, 6'd0);
    repeat (39) send_char(rand_printable(), 6'($urandom));
    send_char(7'h5A, 6'h21);
    check_screen("screen_after_wrap40");

    // Reset in the middle of a clear
    clear_req = 1'b1;
    @(posedge clock);
    #1;
    clear_req = 1'b0;
    repeat (100) @(posedge clock);
    #1;
    check("pre_rst_wren", wren, 1);
    reset = 1'b1;
    #1;
    check("midrst_wren", wren, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cursor_x", cursor_x, 0);
    check("midrst_cursor_y", cursor_y, 0);
    check("midrst_wrx", wrx, 0);
    check("midrst_wry", wry, 0);
    check("midrst_wascii", wascii, 0);
    check("midrst_wcolour", wcolour, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();
    check("midrst_ready", char_ready, 1);
    init_mems();
    ref_mode = sL; ref_x = 0; ref_y = 0;

    // Randomized character stream
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 199);
      if (r < 100)      send_char(rand_printable(), 6'($urandom));
      else if (r < 140) send_char(7'h0A, 6'($urandom));
      else if (r < 155) send_char(7'h0D, 6'($urandom));
      else if (r < 180) send_char(7'h08, 6'($urandom));
      else if (r < 190) send_char(others[$urandom_range(0, 4)], 6'($urandom));
      else if (r < 198) set_mode(ref_mode ^ 1);
      else              do_clear(1'($urandom));
    end
    check_screen("screen_final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
